// File: rtl/tmds_decoder.sv
// rtl/tmds_decoder.sv - TMDS receive channel decoder with bit-slip symbol alignment
//
// Purpose: takes unaligned 10-bit words from a 10:1 deserializer, slips the
// symbol boundary one bit at a time until a run of LOCK_TOKENS control tokens
// is seen, then decodes every aligned symbol into de / ctrl / data.
//
// Ports:
//   clk_pix     in   pixel clock
//   rst_pix     in   asynchronous active-high reset
//   sym_in      in   [9:0] raw deserialized word, bit 0 received first
//   de          out  1 = data symbol decoded this cycle
//   ctrl        out  [1:0] last decoded control token value
//   data        out  [7:0] decoded pixel byte, 0 when de = 0
//   locked      out  symbol alignment locked
//   offset      out  [3:0] current bit-slip offset 0..9
//   slip_count  out  [15:0] saturating slip counter (TMDS_DECODER_STATS_EN only)
//
// Optional feature macro: TMDS_DECODER_STATS_EN
module tmds_decoder #(
  parameter int LOCK_TOKENS = 16,
  parameter int TIMEOUT     = 4096
) (
  input  logic        clk_pix,
  input  logic        rst_pix,
  input  logic [9:0]  sym_in,
  output logic        de,
  output logic [1:0]  ctrl,
  output logic [7:0]  data,
  output logic        locked,
  output logic [3:0]  offset
`ifdef TMDS_DECODER_STATS_EN
  ,
  output logic [15:0] slip_count
`endif
);

  localparam int               TMO_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [7:0]       RUN_MAX  = 8'(LOCK_TOKENS);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [9:0]       sym_prev_q;
  logic [9:0]       aln_q, aln_d;
  logic [3:0]       offset_q, offset_d;
  logic [7:0]       run_q, run_d, run_cnt;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             settle_q, settle_d;
  logic             de_q, de_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic [7:0]       data_q, data_d;

  logic [19:0]      window;
  logic             is_tok;
  logic [1:0]       tok_val;
  logic [7:0]       t;
  logic [7:0]       dec;
  logic             complete;
  logic             expire;

  // Stage 1: the older word sits in the low half, so offset k starts the
  // symbol k bits into the previous word.
  always_comb begin
    window = {sym_in, sym_prev_q};
    aln_d  = 10'(window >> offset_q);
  end

  always_comb begin
    is_tok  = 1'b1;
    tok_val = 2'b00;
    case (aln_q)
      10'b1101010100: tok_val = 2'b00;
      10'b0010101011: tok_val = 2'b01;
      10'b0101010100: tok_val = 2'b10;
      10'b1010101011: tok_val = 2'b11;
      default:        is_tok  = 1'b0;
    endcase
  end

  // Undo the optional inversion, then the XOR/XNOR transition chain.
  always_comb begin
    t      = aln_q[9] ? ~aln_q[7:0] : aln_q[7:0];
    dec    = '0;
    dec[0] = t[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = aln_q[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
    end
  end

  // The word captured on the slip edge was aligned with the old offset, so
  // it is not allowed to count towards a run.
  always_comb begin
    run_cnt = run_q;
    if (settle_q)                run_cnt = '0;
    else if (!is_tok)            run_cnt = '0;
    else if (run_q != RUN_MAX)   run_cnt = run_q + 8'd1;
  end

  assign complete = (run_cnt == RUN_MAX);
  assign expire   = (tmo_q == TMO_LAST) && !complete;

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    run_d    = run_cnt;
    tmo_d    = complete ? '0 : tmo_q + TMO_W'(1);
    settle_d = 1'b0;
    case (state_q)
      SEARCH: begin
        if (complete) begin
          state_d = LOCKED;
        end else if (expire) begin
          offset_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
          run_d    = '0;
          tmo_d    = '0;
          settle_d = 1'b1;
        end
      end
      LOCKED: begin
        if (expire) begin
          state_d = SEARCH;
          run_d   = '0;
          tmo_d   = '0;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  // Stage 2: gated by the registered lock state.
  always_comb begin
    de_d   = 1'b0;
    ctrl_d = 2'b00;
    data_d = 8'h00;
    if (state_q == LOCKED) begin
      if (is_tok) begin
        ctrl_d = tok_val;
      end else begin
        de_d   = 1'b1;
        ctrl_d = ctrl_q;
        data_d = dec;
      end
    end
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      state_q    <= SEARCH;
      sym_prev_q <= '0;
      aln_q      <= '0;
      offset_q   <= '0;
      run_q      <= '0;
      tmo_q      <= '0;
      settle_q   <= 1'b0;
      de_q       <= 1'b0;
      ctrl_q     <= 2'b00;
      data_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      sym_prev_q <= sym_in;
      aln_q      <= aln_d;
      offset_q   <= offset_d;
      run_q      <= run_d;
      tmo_q      <= tmo_d;
      settle_q   <= settle_d;
      de_q       <= de_d;
      ctrl_q     <= ctrl_d;
      data_q     <= data_d;
    end
  end

  assign de     = de_q;
  assign ctrl   = ctrl_q;
  assign data   = data_q;
  assign locked = (state_q == LOCKED);
  assign offset = offset_q;

`ifdef TMDS_DECODER_STATS_EN
  logic        slip;
  logic [15:0] slip_cnt_q;

  assign slip = (state_q == SEARCH) && expire;

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      slip_cnt_q <= '0;
    end else if (slip && (slip_cnt_q != 16'hFFFF)) begin
      slip_cnt_q <= slip_cnt_q + 16'd1;
    end
  end

  assign slip_count = slip_cnt_q;
`endif

endmodule
